// File: rtl/mod_quarter_if.sv
// Operand/result handshake bundle for the modular quartering block.
// oErr exists only when MOD_QUARTER_CHECK_EN is defined.
interface modQuarterIf #(
  parameter int unsigned BITWIDTH = 32
);
  logic                iValid;
  logic                oReady;
  logic [BITWIDTH-1:0] iData;
  logic [BITWIDTH-1:0] iMod;
  logic                oValid;
  logic                iReady;
  logic [BITWIDTH-1:0] oData;
`ifdef MOD_QUARTER_CHECK_EN
  logic                oErr;
`endif

  modport slave (
    input  iValid, iData, iMod, iReady,
    output oReady, oValid, oData
`ifdef MOD_QUARTER_CHECK_EN
    , output oErr
`endif
  );

  modport master (
    output iValid, iData, iMod, iReady,
    input  oReady, oValid, oData
`ifdef MOD_QUARTER_CHECK_EN
    , input oErr
`endif
  );
endinterface

// File: rtl/mod_quarter_reg.sv
// Modular quartering: oData = iData * 4^-1 mod iMod via two modular halvings.
// Optional operand-contract flag on oErr when MOD_QUARTER_CHECK_EN is defined.
module mod_quarter_reg #(
  parameter int unsigned BITWIDTH = 32
) (
  input  logic       iClk,
  input  logic       iRstN,
  input  logic       iEn,
  input  logic       iClr,
  modQuarterIf.slave bus
);

  localparam int unsigned SumW = BITWIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    H1   = 2'd1,
    H2   = 2'd2,
    DONE = 2'd3
  } stateT;

  stateT               state, stateNext;
  logic [BITWIDTH-1:0] xReg, xNext;
  logic [BITWIDTH-1:0] mReg, mNext;

  // Halving mod m: odd x gets m added first; the sum needs one extra carry bit.
  function automatic logic [BITWIDTH-1:0] halfMod(input logic [BITWIDTH-1:0] x,
                                                  input logic [BITWIDTH-1:0] m);
    logic [SumW-1:0] sum;
    sum = SumW'(x) + (x[0] ? SumW'(m) : SumW'(0));
    return sum[SumW-1:1];
  endfunction

`ifdef MOD_QUARTER_CHECK_EN
  logic flagReg, flagNext;
`endif

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= IDLE;
      xReg  <= '0;
      mReg  <= '0;
`ifdef MOD_QUARTER_CHECK_EN
      flagReg <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      xReg  <= xNext;
      mReg  <= mNext;
`ifdef MOD_QUARTER_CHECK_EN
      flagReg <= flagNext;
`endif
    end
  end

  always_comb begin
    stateNext = state;
    xNext     = xReg;
    mNext     = mReg;
`ifdef MOD_QUARTER_CHECK_EN
    flagNext  = flagReg;
`endif
    if (iClr) begin
      stateNext = IDLE;
      xNext     = '0;
      mNext     = '0;
`ifdef MOD_QUARTER_CHECK_EN
      flagNext  = 1'b0;
`endif
    end else if (iEn) begin
      unique case (state)
        IDLE: begin
          if (bus.iValid) begin
            xNext     = bus.iData;
            mNext     = bus.iMod;
            stateNext = H1;
`ifdef MOD_QUARTER_CHECK_EN
            flagNext  = ~bus.iMod[0] | (bus.iData >= bus.iMod);
`endif
          end
        end
        H1: begin
          xNext     = halfMod(xReg, mReg);
          stateNext = H2;
        end
        H2: begin
          xNext     = halfMod(xReg, mReg);
          stateNext = DONE;
        end
        DONE: begin
          if (bus.iReady) stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Handshake flags are pure state decodes; the result is the x register.
  assign bus.oReady = (state == IDLE);
  assign bus.oValid = (state == DONE);
  assign bus.oData  = xReg;
`ifdef MOD_QUARTER_CHECK_EN
  assign bus.oErr   = flagReg & (state == DONE);
`endif

endmodule

// File: tb/tb_mod_quarter_reg.sv
// Self-checking bench for mod_quarter_reg against an arithmetic modular-inverse model.
module tb_mod_quarter_reg;

  localparam int unsigned W = 32;

  logic iClk;
  logic iRstN;
  logic iEn;
  logic iClr;
  int   nChecks;
  int   nErrors;

  modQuarterIf #(.BITWIDTH(W)) bus ();

  mod_quarter_reg #(.BITWIDTH(W)) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iEn   (iEn),
    .iClr  (iClr),
    .bus   (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // y = d * inverse(4) mod m, with inverse(2) = (m+1)/2 for odd m
  function automatic logic [W-1:0] quarterRef(input logic [W-1:0] d, input logic [W-1:0] m);
    logic [63:0] inv2, inv4, prod;
    inv2 = (64'(m) + 64'd1) >> 1;
    inv4 = (inv2 * inv2) % 64'(m);
    prod = (64'(d) % 64'(m)) * inv4;
    return W'(prod % 64'(m));
  endfunction

  function automatic logic [W-1:0] quadRef(input logic [W-1:0] d, input logic [W-1:0] m);
    return W'((64'(d) * 64'd4) % 64'(m));
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Wait for oReady (bounded), then present one operand for exactly the accept edge
  task automatic acceptOp(input logic [W-1:0] d, input logic [W-1:0] m);
    int n;
    n = 0;
    while (!bus.oReady && n < 20) begin
      tick();
      n++;
    end
    nChecks++;
    if (!bus.oReady) begin
      nErrors++;
      $display("FAIL accept_timeout: oReady=%0b required 1", bus.oReady);
    end
    bus.iValid = 1'b1;
    bus.iData  = d;
    bus.iMod   = m;
    tick();
    bus.iValid = 1'b0;
    bus.iData  = $urandom;
    bus.iMod   = $urandom;
  endtask

  // lat counts posedges from (and including) the accept edge until oValid is seen
  task automatic waitDone(inout int lat);
    while (!bus.oValid && lat < 30) begin
      tick();
      lat++;
    end
    nChecks++;
    if (!bus.oValid) begin
      nErrors++;
      $display("FAIL done_timeout: oValid=%0b required 1", bus.oValid);
    end
  endtask

  task automatic releaseOp();
    bus.iReady = 1'b1;
    tick();
    bus.iReady = 1'b0;
  endtask

  task automatic runOp(input logic [W-1:0] d, input logic [W-1:0] m,
                       output logic [W-1:0] y, output int lat);
    acceptOp(d, m);
    lat = 1;
    waitDone(lat);
    y = bus.oData;
    releaseOp();
  endtask

  task automatic test_reset();
    iRstN = 1'b0;
    #12;
    nChecks++;
    if (bus.oReady !== 1'b1 || bus.oValid !== 1'b0 || bus.oData !== '0) begin
      nErrors++;
      $display("FAIL reset: oReady=%0b oValid=%0b oData=%h required 1 0 0",
               bus.oReady, bus.oValid, bus.oData);
    end
    @(negedge iClk);
    iRstN = 1'b1;
    tick();
  endtask

  task automatic test_vectors();
    logic [W-1:0] dv [6];
    logic [W-1:0] mv [6];
    logic [W-1:0] ev [6];
    logic [W-1:0] y;
    int lat;
    dv = '{32'd1, 32'd4, 32'd0, 32'd22, 32'd1, 32'hFFFF_FFF9};
    mv = '{32'd23, 32'd23, 32'd23, 32'd23, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    ev = '{32'd6, 32'd1, 32'd0, 32'd17, 32'h3FFF_FFFF, 32'h7FFF_FFFD};
    for (int i = 0; i < 6; i++) begin
      runOp(dv[i], mv[i], y, lat);
      nChecks++;
      if (y !== ev[i]) begin
        nErrors++;
        $display("FAIL vector%0d_data: got %h required %h", i, y, ev[i]);
      end
      nChecks++;
      if (lat != 3) begin
        nErrors++;
        $display("FAIL vector%0d_latency: got %0d required 3", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp;
    int lat;
    exp = quarterRef(32'd9, 32'd23);
    acceptOp(32'd9, 32'd23);
    lat = 1;
    waitDone(lat);
    bus.iValid = 1'b1;
    bus.iData  = 32'd5;
    bus.iMod   = 32'd23;
    for (int i = 0; i < 5; i++) begin
      nChecks++;
      if (bus.oValid !== 1'b1 || bus.oReady !== 1'b0 || bus.oData !== exp) begin
        nErrors++;
        $display("FAIL stall%0d: oValid=%0b oReady=%0b oData=%h required 1 0 %h",
                 i, bus.oValid, bus.oReady, bus.oData, exp);
      end
      tick();
    end
    bus.iValid = 1'b0;
    releaseOp();
    nChecks++;
    if (bus.oValid !== 1'b0 || bus.oReady !== 1'b1 || bus.oData !== exp) begin
      nErrors++;
      $display("FAIL stall_release: oValid=%0b oReady=%0b oData=%h required 0 1 %h",
               bus.oValid, bus.oReady, bus.oData, exp);
    end
  endtask

  task automatic test_enable();
    logic [W-1:0] exp;
    int lat;
    exp = quarterRef(32'd13, 32'd23);
    acceptOp(32'd13, 32'd23);
    lat = 1;
    iEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      lat++;
      nChecks++;
      if (bus.oValid !== 1'b0 || bus.oReady !== 1'b0) begin
        nErrors++;
        $display("FAIL enable_hold%0d: oValid=%0b oReady=%0b required 0 0",
                 i, bus.oValid, bus.oReady);
      end
    end
    iEn = 1'b1;
    waitDone(lat);
    nChecks++;
    if (lat != 6 || bus.oData !== exp) begin
      nErrors++;
      $display("FAIL enable_result: lat=%0d oData=%h required 6 %h", lat, bus.oData, exp);
    end
    releaseOp();
  endtask

  task automatic test_clear();
    acceptOp(32'd17, 32'd23);
    tick();
    iClr = 1'b1;
    tick();
    iClr = 1'b0;
    nChecks++;
    if (bus.oReady !== 1'b1 || bus.oValid !== 1'b0 || bus.oData !== '0) begin
      nErrors++;
      $display("FAIL clear: oReady=%0b oValid=%0b oData=%h required 1 0 0",
               bus.oReady, bus.oValid, bus.oData);
    end
  endtask

  task automatic test_roundtrip();
    logic [W-1:0] d, q, y;
    int lat;
    for (int i = 0; i < 16; i++) begin
      d = W'($urandom_range(0, 22));
      q = quadRef(d, 32'd23);
      runOp(q, 32'd23, y, lat);
      nChecks++;
      if (y !== d) begin
        nErrors++;
        $display("FAIL roundtrip%0d: x4=%0d quartered=%0d required %0d", i, q, y, d);
      end
    end
  endtask

  task automatic test_random_wide();
    logic [W-1:0] d, m, y, e;
    int lat;
    for (int i = 0; i < 24; i++) begin
      m = $urandom | 32'd1;
      if (m < 32'd3) m = 32'd3;
      d = $urandom % m;
      e = quarterRef(d, m);
      runOp(d, m, y, lat);
      nChecks++;
      if (y !== e || lat != 3) begin
        nErrors++;
        $display("FAIL random%0d: d=%h m=%h got %h lat=%0d required %h lat=3",
                 i, d, m, y, lat, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] y;
    int lat;
    for (int i = 0; i < 4; i++) begin
      bus.iReady = 1'b1;
      acceptOp(W'(i * 5), 32'd23);
      lat = 1;
      waitDone(lat);
      y = bus.oData;
      tick();
      nChecks++;
      if (y !== quarterRef(W'(i * 5), 32'd23) || bus.oReady !== 1'b1) begin
        nErrors++;
        $display("FAIL b2b%0d: got %h oReady=%0b required %h 1",
                 i, y, bus.oReady, quarterRef(W'(i * 5), 32'd23));
      end
    end
    bus.iReady = 1'b0;
  endtask

`ifdef MOD_QUARTER_CHECK_EN
  task automatic test_err();
    logic [W-1:0] dv [3];
    logic [W-1:0] mv [3];
    logic         ev [3];
    int lat;
    dv = '{32'd5, 32'd23, 32'd5};
    mv = '{32'd24, 32'd23, 32'd23};
    ev = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      acceptOp(dv[i], mv[i]);
      lat = 1;
      waitDone(lat);
      nChecks++;
      if (bus.oErr !== ev[i]) begin
        nErrors++;
        $display("FAIL err%0d: oErr=%0b required %0b", i, bus.oErr, ev[i]);
      end
      releaseOp();
    end
  endtask
`endif

  initial begin
    nChecks    = 0;
    nErrors    = 0;
    iEn        = 1'b1;
    iClr       = 1'b0;
    bus.iValid = 1'b0;
    bus.iReady = 1'b0;
    bus.iData  = '0;
    bus.iMod   = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_enable();
    test_clear();
    test_roundtrip();
    test_random_wide();
    test_back_to_back();
`ifdef MOD_QUARTER_CHECK_EN
    test_err();
`endif
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
